// File: rtl/falling_cubes_pkg.sv
// Shared definitions for the falling-cubes button front-ends.
// Holds the 3-bit FSM state encoding and the default board timing constants.
// No logic; imported by generador_rotar and sibling input blocks.
package falling_cubes_pkg;

  // Button front-end FSM states (3-bit encoding shared across front-ends)
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_DEB_PRESS   = 3'd1,
    ST_HELD        = 3'd2,
    ST_REPEAT      = 3'd3,
    ST_DEB_RELEASE = 3'd4
  } estado_t;

  // Board timing defaults
  localparam int CLK_FREQ_HZ      = 50_000_000;
  localparam int DEBOUNCE_MS      = 10;
  localparam int REPEAT_DELAY_MS  = 500;
  localparam int REPEAT_PERIOD_MS = 200;

  localparam int DEF_DEBOUNCE_CYCLES = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;
  localparam int DEF_REPEAT_DELAY    = (CLK_FREQ_HZ / 1000) * REPEAT_DELAY_MS;
  localparam int DEF_REPEAT_PERIOD   = (CLK_FREQ_HZ / 1000) * REPEAT_PERIOD_MS;

  // Largest of three values, used to size a counter shared by several timeouts
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Generic 2-flop synchroniser for a single asynchronous level.
// Latency: 2 clock cycles from input change to o_q.
// No backpressure; free-running, async active-low reset clears both flops.
module sincronizador_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two back-to-back flops; only r_sync is safe to use downstream
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/generador_rotar.sv
// Rotate push-button front-end: sync, debounce, press-edge pulse, optional hold-to-repeat.
// Latency: rotar/pulsado rise DEBOUNCE_CYCLES+2 cycles after a clean press (+-1 sync window).
// No backpressure: habilitar=0 drops a pulse (never deferred); FSM keeps tracking the button.
// Build option: define GENERADOR_ROTAR_AUTOREPEAT_EN to enable hold-to-repeat pulses.
module generador_rotar
  import falling_cubes_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic boton_async,
  input  logic habilitar,
  output logic rotar,
  output logic pulsado
);

`ifdef GENERADOR_ROTAR_AUTOREPEAT_EN
  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
`else
  // Repeat timings do not influence the width here (multiplied by zero) when repeat is off
  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, 0 * REPEAT_DELAY, 0 * REPEAT_PERIOD)) + 1;
`endif

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef GENERADOR_ROTAR_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

  logic             w_boton_s;
  estado_t          r_state;
  estado_t          w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_rotar;
  logic             w_rotar_nxt;
  logic             r_pulsado;
  logic             w_pulsado_nxt;

  sincronizador_2ff u_sync (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_d     (boton_async),
    .o_q     (w_boton_s)
  );

  // State, shared counter and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_rotar   <= 1'b0;
      r_pulsado <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rotar   <= w_rotar_nxt;
      r_pulsado <= w_pulsado_nxt;
    end
  end

  // Next state / counter / output decode; counter is cleared on every state change
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_rotar_nxt   = 1'b0;
    w_pulsado_nxt = r_pulsado;

    case (r_state)
      ST_IDLE: begin
        if (w_boton_s) begin
          w_state_nxt = ST_DEB_PRESS;
          w_cnt_nxt   = '0;
        end
      end

      ST_DEB_PRESS: begin
        if (!w_boton_s) begin
          // Glitch shorter than the debounce window: back to idle, no pulse
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt   = ST_HELD;
          w_cnt_nxt     = '0;
          w_pulsado_nxt = 1'b1;
          w_rotar_nxt   = habilitar;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      ST_HELD: begin
        if (!w_boton_s) begin
          w_state_nxt = ST_DEB_RELEASE;
          w_cnt_nxt   = '0;
        end
`ifdef GENERADOR_ROTAR_AUTOREPEAT_EN
        else if (r_cnt == DELAY_LAST) begin
          w_state_nxt = ST_REPEAT;
          w_cnt_nxt   = '0;
          w_rotar_nxt = habilitar;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
`endif
        // Without repeat the counter stays at zero here, so it can never wrap while held
      end

      ST_REPEAT: begin
`ifdef GENERADOR_ROTAR_AUTOREPEAT_EN
        if (!w_boton_s) begin
          w_state_nxt = ST_DEB_RELEASE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == PERIOD_LAST) begin
          w_cnt_nxt   = '0;
          w_rotar_nxt = habilitar;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
`else
        // Unreachable when repeat is off; recover cleanly
        w_state_nxt   = ST_IDLE;
        w_cnt_nxt     = '0;
        w_pulsado_nxt = 1'b0;
`endif
      end

      ST_DEB_RELEASE: begin
        if (w_boton_s) begin
          // Release bounce: return to held without a new pulse
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt   = ST_IDLE;
          w_cnt_nxt     = '0;
          w_pulsado_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt   = ST_IDLE;
        w_cnt_nxt     = '0;
        w_pulsado_nxt = 1'b0;
      end
    endcase
  end

  assign rotar   = r_rotar;
  assign pulsado = r_pulsado;

endmodule

// File: tb/tb_generador_rotar.sv
// Self-checking bench for generador_rotar with short timing parameters.
// Expected rotar pulse cycles are queued when a press is driven and popped on each pulse.
// Pulsado and idle conditions are checked inline by each scenario task.
module tb_generador_rotar;

  logic clk;
  logic reset;
  logic boton_async;
  logic habilitar;
  logic rotar;
  logic pulsado;

  int cyc;
  int checks;
  int errors;
  int exp_q[$];
  logic prev_rot;

  generador_rotar #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .boton_async (boton_async),
    .habilitar   (habilitar),
    .rotar       (rotar),
    .pulsado     (pulsado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every rotar pulse must match the oldest expected cycle
  always @(negedge clk) begin
    if (reset) begin
      if (rotar) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pulse_unexpected: rotar=1 at cycle %0d, required no pulse", cyc);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (cyc !== e) begin
            errors++;
            $display("FAIL pulse_cycle: rotar at cycle %0d, required cycle %0d", cyc, e);
          end
        end
        if (prev_rot) begin
          checks++;
          errors++;
          $display("FAIL pulse_width: rotar high two cycles in a row at cycle %0d, required 1-cycle", cyc);
        end
      end
      prev_rot = rotar;
    end else begin
      prev_rot = 1'b0;
    end
  end

  // Advance to the negedge where cyc equals c
  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_queue_empty(input string name);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL %s: %0d expected pulses never seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    int t;
    reset = 1'b0;
    boton_async = 1'b1;
    habilitar = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rotar !== 1'b0 || pulsado !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: rotar=%b pulsado=%b, required 0 0", rotar, pulsado);
      end
    end
    // Release reset with the button still held: treated as a fresh press
    reset = 1'b1;
    t = cyc + 1;
    exp_q.push_back(t + 6);
    at_cyc(t + 7);
    checks++;
    if (pulsado !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_pulsado: pulsado=%b, required 1", pulsado);
    end
    boton_async = 1'b0;
    at_cyc(t + 25);
    checks++;
    if (pulsado !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: pulsado=%b, required 0", pulsado);
    end
    check_queue_empty("reset_release_pulses");
  endtask

  task automatic test_clean_press;
    int t;
    @(negedge clk);
    habilitar = 1'b1;
    boton_async = 1'b1;
    t = cyc + 1;
    exp_q.push_back(t + 6);
    at_cyc(t + 5);
    checks++;
    if (pulsado !== 1'b0) begin
      errors++;
      $display("FAIL clean_pulsado_early: pulsado=%b at t+5, required 0", pulsado);
    end
    at_cyc(t + 6);
    checks++;
    if (pulsado !== 1'b1) begin
      errors++;
      $display("FAIL clean_pulsado_rise: pulsado=%b at t+6, required 1", pulsado);
    end
    at_cyc(t + 7);
    boton_async = 1'b0;
    at_cyc(t + 25);
    checks++;
    if (pulsado !== 1'b0) begin
      errors++;
      $display("FAIL clean_pulsado_fall: pulsado=%b, required 0", pulsado);
    end
    check_queue_empty("clean_pulses");
  endtask

  task automatic test_bounce;
    logic seen;
    logic pat [6];
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    seen = 1'b0;
    habilitar = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      boton_async = pat[i];
      if (pulsado) seen = 1'b1;
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (pulsado) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL bounce_pulsado: pulsado went %b during glitches, required 0", seen);
    end
    check_queue_empty("bounce_pulses");
  endtask

  task automatic test_release_bounce;
    int t;
    @(negedge clk);
    habilitar = 1'b1;
    boton_async = 1'b1;
    t = cyc + 1;
    exp_q.push_back(t + 6);
    at_cyc(t + 7);
    boton_async = 1'b0;
    at_cyc(t + 9);
    boton_async = 1'b1;
    at_cyc(t + 11);
    boton_async = 1'b0;
    at_cyc(t + 13);
    checks++;
    if (pulsado !== 1'b1) begin
      errors++;
      $display("FAIL relbounce_hold: pulsado=%b at t+13, required 1", pulsado);
    end
    at_cyc(t + 17);
    checks++;
    if (pulsado !== 1'b1) begin
      errors++;
      $display("FAIL relbounce_before_fall: pulsado=%b at t+17, required 1", pulsado);
    end
    at_cyc(t + 18);
    checks++;
    if (pulsado !== 1'b0) begin
      errors++;
      $display("FAIL relbounce_fall: pulsado=%b at t+18, required 0", pulsado);
    end
    at_cyc(t + 25);
    check_queue_empty("relbounce_pulses");
  endtask

  task automatic test_autorepeat;
    int t;
    @(negedge clk);
    habilitar = 1'b1;
    boton_async = 1'b1;
    t = cyc + 1;
    exp_q.push_back(t + 6);
`ifdef GENERADOR_ROTAR_AUTOREPEAT_EN
    exp_q.push_back(t + 16);
    exp_q.push_back(t + 19);
    exp_q.push_back(t + 22);
    exp_q.push_back(t + 25);
    exp_q.push_back(t + 28);
`endif
    at_cyc(t + 27);
    boton_async = 1'b0;
    at_cyc(t + 45);
    checks++;
    if (pulsado !== 1'b0) begin
      errors++;
      $display("FAIL repeat_release: pulsado=%b, required 0", pulsado);
    end
    check_queue_empty("repeat_pulses");
  endtask

  task automatic test_habilitar;
    int t;
    @(negedge clk);
    habilitar = 1'b0;
    boton_async = 1'b1;
    t = cyc + 1;
    at_cyc(t + 7);
    checks++;
    if (pulsado !== 1'b1) begin
      errors++;
      $display("FAIL hab_pulsado: pulsado=%b, required 1", pulsado);
    end
    // Enabling later must not resurrect the dropped pulse
    habilitar = 1'b1;
    at_cyc(t + 9);
    boton_async = 1'b0;
    at_cyc(t + 25);
    checks++;
    if (pulsado !== 1'b0) begin
      errors++;
      $display("FAIL hab_release: pulsado=%b, required 0", pulsado);
    end
    check_queue_empty("hab_pulses");
  endtask

  initial begin
    cyc = 0;
    checks = 0;
    errors = 0;
    prev_rot = 1'b0;
    reset = 1'b0;
    boton_async = 1'b0;
    habilitar = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_autorepeat();
    test_habilitar();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
